tt7_extractor: RTL and testbench

- Sequential truth-table extractor/checker for 7-input single-output combinational functions of the kind held in the classification library.
- Drives all 128 input minterms into a function-under-test (FUT), samples its output and assembles the 128-bit truth table in the library's hex ordering.
- Optionally compares the extracted table against an expected table.
- Sits in the verification/characterisation harness, as the consumer on the other end of the function's x0..x6 → out interface.

---
 rtl/tt7_extractor_if.sv | 25 ++
 rtl/tt7_extractor.sv | 177 +++++++++++++++++
 tb/tb_tt7_extractor.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/tt7_extractor_if.sv
// Bus between the truth-table extractor and its user/function-under-test.
// The slave side is the extractor; the master side drives control and f_in.
interface tt7_extractor_if;
  logic         start;
  logic         abort;
  logic [127:0] expected;
  logic [6:0]   x;
  logic         f_in;
  logic         busy;
  logic         done;
  logic [127:0] tt;
  logic [7:0]   ones_count;
  logic         match;
  logic [6:0]   first_mismatch;

  modport master (
    output start, abort, expected, f_in,
    input  x, busy, done, tt, ones_count, match, first_mismatch
  );

  modport slave (
    input  start, abort, expected, f_in,
    output x, busy, done, tt, ones_count, match, first_mismatch
  );
endinterface

// File: rtl/tt7_extractor.sv
// Sequential truth-table extractor for 7-input single-output functions.
// Walks x through all 128 minterms, waits SETTLE cycles per minterm, samples
// f_in into tt[x], counts ones and compares against a latched expected table.
module tt7_extractor #(
  parameter int SETTLE = 0,
  parameter int CNT_W  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  tt7_extractor_if.slave   bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] SETTLE_C = CNT_W'(SETTLE);
  localparam logic [6:0]       LAST_IDX = 7'd127;

  state_t           state_q, state_d;
  logic [6:0]       idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [6:0]       x_q, x_d;
  logic [127:0]     tt_q, tt_d;
  logic [7:0]       ones_q, ones_d;
  logic             match_q, match_d;
  logic [6:0]       first_mismatch_q, first_mismatch_d;
  logic [127:0]     exp_q, exp_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  // Sample-cycle qualifiers derived from the current position in the run.
  logic             sample_s;
  logic             last_s;
  logic             miss_s;

  // Decode whether this RUN cycle samples f_in and whether it disagrees.
  always_comb begin
    sample_s = 1'b0;
    last_s   = 1'b0;
    miss_s   = 1'b0;
    if (cnt_q == SETTLE_C) begin
      sample_s = 1'b1;
    end else begin
      sample_s = 1'b0;
    end
    if (idx_q == LAST_IDX) begin
      last_s = 1'b1;
    end else begin
      last_s = 1'b0;
    end
    if (bus.f_in != exp_q[idx_q]) begin
      miss_s = 1'b1;
    end else begin
      miss_s = 1'b0;
    end
  end

  // Next-state and next-output logic for the IDLE -> RUN -> DONE sequence.
  always_comb begin
    state_d          = state_q;
    idx_d            = idx_q;
    cnt_d            = cnt_q;
    x_d              = x_q;
    tt_d             = tt_q;
    ones_d           = ones_q;
    match_d          = match_q;
    first_mismatch_d = first_mismatch_q;
    exp_d            = exp_q;
    busy_d           = busy_q;
    done_d           = 1'b0;

    case (state_q)
      S_IDLE: begin
        // start beats abort here: abort has no meaning while idle
        if (bus.start) begin
          exp_d            = bus.expected;
          tt_d             = 128'd0;
          ones_d           = 8'd0;
          first_mismatch_d = 7'd0;
          match_d          = 1'b1;
          idx_d            = 7'd0;
          x_d              = 7'd0;
          cnt_d            = {CNT_W{1'b0}};
          busy_d           = 1'b1;
          state_d          = S_RUN;
        end else begin
          state_d = S_IDLE;
        end
      end

      S_RUN: begin
        if (bus.abort) begin
          // partial tt is kept; match/first_mismatch are meaningless now
          state_d = S_IDLE;
          busy_d  = 1'b0;
          x_d     = 7'd0;
        end else if (sample_s) begin
          tt_d[idx_q] = bus.f_in;
          ones_d      = ones_q + {7'd0, bus.f_in};
          // only the lowest failing index is recorded
          if (miss_s && match_q) begin
            match_d          = 1'b0;
            first_mismatch_d = idx_q;
          end else begin
            match_d          = match_q;
          end
          if (last_s) begin
            state_d = S_DONE;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            x_d     = 7'd0;
          end else begin
            idx_d = idx_q + 7'd1;
            x_d   = idx_q + 7'd1;
            cnt_d = {CNT_W{1'b0}};
          end
        end else begin
          cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end

      S_DONE: begin
        // done is high for exactly this one cycle
        state_d = S_IDLE;
        busy_d  = 1'b0;
        x_d     = 7'd0;
      end

      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        x_d     = 7'd0;
      end
    endcase
  end

  // State and result registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q          <= S_IDLE;
      idx_q            <= 7'd0;
      cnt_q            <= {CNT_W{1'b0}};
      x_q              <= 7'd0;
      tt_q             <= 128'd0;
      ones_q           <= 8'd0;
      match_q          <= 1'b1;
      first_mismatch_q <= 7'd0;
      exp_q            <= 128'd0;
      busy_q           <= 1'b0;
      done_q           <= 1'b0;
    end else begin
      state_q          <= state_d;
      idx_q            <= idx_d;
      cnt_q            <= cnt_d;
      x_q              <= x_d;
      tt_q             <= tt_d;
      ones_q           <= ones_d;
      match_q          <= match_d;
      first_mismatch_q <= first_mismatch_d;
      exp_q            <= exp_d;
      busy_q           <= busy_d;
      done_q           <= done_d;
    end
  end

  assign bus.x              = x_q;
  assign bus.busy           = busy_q;
  assign bus.done           = done_q;
  assign bus.tt             = tt_q;
  assign bus.ones_count     = ones_q;
  assign bus.match          = match_q;
  assign bus.first_mismatch = first_mismatch_q;

endmodule

// File: tb/tb_tt7_extractor.sv
// Self-checking bench for tt7_extractor: two instances (SETTLE=0 and 3) driven
// by a table-lookup function-under-test, checked against a reference model.
module tb_tt7_extractor;

  logic         clk;
  logic         rst_n;
  bit           sel;        // 0 -> settle-0 instance, 1 -> settle-3 instance
  logic         start_v;
  logic         abort_v;
  logic [127:0] exp_v;
  logic [127:0] fut_tt;     // function under test as a lookup table

  int n_checks;
  int n_fail;

  tt7_extractor_if bus0();
  tt7_extractor_if bus3();

  tt7_extractor #(.SETTLE(0), .CNT_W(8)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
  tt7_extractor #(.SETTLE(3), .CNT_W(8)) dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3));

  assign bus0.start    = start_v & ~sel;
  assign bus3.start    = start_v & sel;
  assign bus0.abort    = abort_v & ~sel;
  assign bus3.abort    = abort_v & sel;
  assign bus0.expected = exp_v;
  assign bus3.expected = exp_v;
  assign bus0.f_in     = fut_tt[bus0.x];
  assign bus3.f_in     = fut_tt[bus3.x];

  logic [6:0]   x_m;
  logic         busy_m, done_m, match_m;
  logic [127:0] tt_m;
  logic [7:0]   ones_m;
  logic [6:0]   fm_m;
  assign x_m     = sel ? bus3.x              : bus0.x;
  assign busy_m  = sel ? bus3.busy           : bus0.busy;
  assign done_m  = sel ? bus3.done           : bus0.done;
  assign match_m = sel ? bus3.match          : bus0.match;
  assign tt_m    = sel ? bus3.tt             : bus0.tt;
  assign ones_m  = sel ? bus3.ones_count     : bus0.ones_count;
  assign fm_m    = sel ? bus3.first_mismatch : bus0.first_mismatch;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] req);
    n_checks++;
    if (obs !== req) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, req);
    end
  endtask

  function automatic logic [7:0] model_ones(input logic [127:0] t);
    int n = 0;
    for (int i = 0; i < 128; i++) n += int'(t[i]);
    return 8'(n);
  endfunction

  function automatic logic [6:0] model_first(input logic [127:0] t, input logic [127:0] e);
    for (int i = 0; i < 128; i++) if (t[i] != e[i]) return 7'(i);
    return 7'd0;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic [127:0] flip_some(input logic [127:0] t);
    logic [127:0] r = t;
    int k = $urandom_range(0, 3);
    for (int i = 0; i < k; i++) r[$urandom_range(0, 127)] ^= 1'b1;
    return r;
  endfunction

  // One extraction run. Event cycles are counted from the first RUN cycle;
  // a negative value disables that event.
  task automatic run_check(input string tag, input bit s, input logic [127:0] fut,
                           input logic [127:0] ex, input bit abort_with_start,
                           input int restart_at, input int abort_at, input int rst_at);
    int len   = s ? 4 : 1;
    int total = 128 * len;
    logic [127:0] mask;
    int nsamp;
    @(negedge clk);
    sel     = s;
    fut_tt  = fut;
    exp_v   = ex;
    start_v = 1'b1;
    abort_v = abort_with_start;
    @(negedge clk);
    start_v = 1'b0;
    abort_v = 1'b0;
    check_eq({tag, " tt_cleared"}, tt_m, 128'd0);
    for (int cyc = 0; cyc < total; cyc++) begin
      check_eq({tag, " x_step"}, {121'd0, x_m}, 128'(cyc / len));
      check_eq({tag, " busy_run"}, {127'd0, busy_m}, 128'd1);
      check_eq({tag, " done_low"}, {127'd0, done_m}, 128'd0);
      if (cyc == restart_at) begin
        start_v = 1'b1;
        exp_v   = ~ex;
      end
      if (cyc == abort_at) abort_v = 1'b1;
      if (cyc == rst_at) rst_n = 1'b0;
      @(negedge clk);
      start_v = 1'b0;
      abort_v = 1'b0;
      if (cyc == abort_at) begin
        nsamp = cyc / len;
        mask  = (nsamp == 0) ? 128'd0 : ({128{1'b1}} >> (128 - nsamp));
        check_eq({tag, " abort_busy"}, {127'd0, busy_m}, 128'd0);
        check_eq({tag, " abort_x"}, {121'd0, x_m}, 128'd0);
        check_eq({tag, " abort_tt"}, tt_m, fut & mask);
        for (int j = 0; j < 4; j++) begin
          check_eq({tag, " abort_nodone"}, {127'd0, done_m}, 128'd0);
          @(negedge clk);
        end
        return;
      end
      if (cyc == rst_at) begin
        rst_n = 1'b1;
        check_eq({tag, " rst_busy"}, {127'd0, busy_m}, 128'd0);
        check_eq({tag, " rst_x"}, {121'd0, x_m}, 128'd0);
        check_eq({tag, " rst_tt"}, tt_m, 128'd0);
        check_eq({tag, " rst_ones"}, {120'd0, ones_m}, 128'd0);
        check_eq({tag, " rst_match"}, {127'd0, match_m}, 128'd1);
        check_eq({tag, " rst_done"}, {127'd0, done_m}, 128'd0);
        return;
      end
    end
    check_eq({tag, " done_pulse"}, {127'd0, done_m}, 128'd1);
    check_eq({tag, " busy_end"}, {127'd0, busy_m}, 128'd0);
    check_eq({tag, " x_end"}, {121'd0, x_m}, 128'd0);
    check_eq({tag, " tt"}, tt_m, fut);
    check_eq({tag, " ones"}, {120'd0, ones_m}, {120'd0, model_ones(fut)});
    check_eq({tag, " match"}, {127'd0, match_m}, {127'd0, (fut == ex)});
    check_eq({tag, " first_mm"}, {121'd0, fm_m}, {121'd0, model_first(fut, ex)});
    @(negedge clk);
    check_eq({tag, " done_once"}, {127'd0, done_m}, 128'd0);
    check_eq({tag, " tt_hold"}, tt_m, fut);
    check_eq({tag, " match_hold"}, {127'd0, match_m}, {127'd0, (fut == ex)});
  endtask

  logic [127:0] t_x0, t_x6, t_maj, t_r, t_e;

  initial begin
    n_checks = 0;
    n_fail   = 0;
    sel      = 1'b0;
    start_v  = 1'b0;
    abort_v  = 1'b0;
    exp_v    = 128'd0;
    fut_tt   = 128'd0;
    rst_n    = 1'b0;
    for (int i = 0; i < 128; i++) begin
      t_x0[i]  = (i % 2) == 1;
      t_x6[i]  = i >= 64;
      t_maj[i] = ((i % 2) + ((i / 2) % 2) + ((i / 4) % 2)) >= 2;
    end
    repeat (3) @(negedge clk);
    check_eq("reset x", {121'd0, bus0.x}, 128'd0);
    check_eq("reset busy", {127'd0, bus0.busy}, 128'd0);
    check_eq("reset done", {127'd0, bus0.done}, 128'd0);
    check_eq("reset tt", bus0.tt, 128'd0);
    check_eq("reset ones", {120'd0, bus0.ones_count}, 128'd0);
    check_eq("reset match", {127'd0, bus0.match}, 128'd1);
    check_eq("reset fm", {121'd0, bus0.first_mismatch}, 128'd0);
    check_eq("reset3 match", {127'd0, bus3.match}, 128'd1);
    rst_n = 1'b1;

    check_eq("x0 table const", t_x0, {32{4'hA}});
    run_check("x0", 1'b0, t_x0, {32{4'hA}}, 1'b0, -1, -1, -1);
    run_check("x6_s3", 1'b1, t_x6, t_x6, 1'b0, -1, -1, -1);
    t_e = ~128'd0;
    t_e[5] = 1'b0;
    run_check("const1", 1'b0, ~128'd0, t_e, 1'b0, -1, -1, -1);
    t_e = t_maj;
    t_e[7] = ~t_e[7];
    t_e[3] = ~t_e[3];
    run_check("maj", 1'b0, t_maj, t_e, 1'b0, -1, -1, -1);

    t_r = rand128();
    run_check("restart40", 1'b0, t_r, flip_some(t_r), 1'b0, 40, -1, -1);
    t_r = rand128();
    run_check("abort60", 1'b0, t_r, t_r, 1'b0, -1, 60, -1);
    t_r = rand128();
    run_check("abort127", 1'b0, t_r, t_r, 1'b0, -1, 127, -1);
    t_r = rand128();
    run_check("abort60_s3", 1'b1, t_r, t_r, 1'b0, -1, 60, -1);
    t_r = rand128();
    run_check("rst70", 1'b0, t_r, t_r, 1'b0, -1, -1, 70);
    t_r = rand128();
    run_check("after_rst", 1'b0, t_r, flip_some(t_r), 1'b0, -1, -1, -1);
    t_r = rand128();
    run_check("start_abort", 1'b0, t_r, t_r, 1'b1, -1, -1, -1);

    for (int k = 0; k < 4; k++) begin
      t_r = rand128();
      run_check("rand", k[0], t_r, flip_some(t_r), 1'b0, -1, -1, -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
